// File: rtl/nvr_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nvr_seq_ctrl                                                 |
// | Description : Host access port and store/recall sequencer for a set of NVR |
// |               macros sharing one charge pump.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nvr_seq_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int NBANK    = 2,
    parameter int PUMP_CYC = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    // host port
    input  logic                              CE,
    input  logic                              WE,
    input  logic [$clog2(NBANK)+ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]                 DIN,
    output logic [DATA_W-1:0]                 DOUT,
    output logic                              DVALID,
    output logic                              RDY,
    // store/recall operation port
    input  logic                              ST_REQ,
    input  logic                              RC_REQ,
    input  logic [NBANK-1:0]                  BMASK,
    output logic                              OP_DONE,
    output logic [NBANK-1:0]                  OP_ERR,
    // macro port
    output logic [NBANK-1:0]                  M_CE,
    output logic                              M_WE,
    output logic [ADDR_W-1:0]                 M_A,
    output logic [DATA_W-1:0]                 M_DIN,
    input  logic [NBANK*DATA_W-1:0]           M_DOUT,
    output logic [NBANK-1:0]                  M_HS,
    output logic [NBANK-1:0]                  M_HR,
    input  logic [NBANK-1:0]                  M_BUSY,
    output logic                              PUMP_EN
);

    localparam int c_BANK_W  = $clog2(NBANK);
    localparam int c_CNT_MAX = (PUMP_CYC > TIMEOUT) ? PUMP_CYC : TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PUMP_LAST = c_CNT_W'(PUMP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PUMP  = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_NEXT  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]          r_state;
    logic                r_rdy;
    logic                r_is_store;
    logic [NBANK-1:0]    r_mask;
    logic [c_BANK_W-1:0] r_bank;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_pump_en;
    logic [NBANK-1:0]    r_hs;
    logic [NBANK-1:0]    r_hr;
    logic                r_op_done;
    logic [NBANK-1:0]    r_op_err;

    logic                r_rd_v;
    logic [c_BANK_W-1:0] r_rd_bank;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dvalid;

    logic                w_op_acc;
    logic                w_host_acc;
    logic [c_BANK_W-1:0] w_host_bank;
    logic [c_BANK_W-1:0] w_next_bank;
    logic [NBANK-1:0]    w_bank_1h;
    logic                w_bank_busy;
    logic [DATA_W-1:0]   w_rd_word;

    // An accepted op request wins over a host access offered in the same cycle.
    assign w_op_acc    = (r_state == c_ST_IDLE) && (ST_REQ || RC_REQ) && (|BMASK);
    assign w_host_acc  = CE && r_rdy && !w_op_acc;
    assign w_host_bank = A[ADDR_W +: c_BANK_W];
    assign w_bank_busy = M_BUSY[r_bank];

    always_comb begin
        w_next_bank = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_next_bank = c_BANK_W'(i);
            end
        end
        w_bank_1h = NBANK'(1) << w_next_bank;
    end

    always_comb begin
        M_CE = '0;
        if (w_host_acc) begin
            M_CE[w_host_bank] = 1'b1;
        end
    end

    assign M_WE  = w_host_acc & WE;
    assign M_A   = A[ADDR_W-1:0];
    assign M_DIN = DIN;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state    <= c_ST_IDLE;
            r_rdy      <= 1'b1;
            r_is_store <= 1'b0;
            r_mask     <= '0;
            r_bank     <= '0;
            r_cnt      <= '0;
            r_pump_en  <= 1'b0;
            r_hs       <= '0;
            r_hr       <= '0;
            r_op_done  <= 1'b0;
            r_op_err   <= '0;
        end else begin
            r_op_done <= 1'b0;
            r_hs      <= '0;
            r_hr      <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_op_acc) begin
                        r_mask     <= BMASK;
                        r_is_store <= ST_REQ;
                        r_op_err   <= '0;
                        r_rdy      <= 1'b0;
                        r_cnt      <= '0;
                        if (ST_REQ) begin
                            r_state   <= c_ST_PUMP;
                            r_pump_en <= 1'b1;
                        end else begin
                            r_state   <= c_ST_NEXT;
                        end
                    end
                end
                c_ST_PUMP: begin
                    if (r_cnt == c_PUMP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_NEXT: begin
                    if (|r_mask) begin
                        r_bank  <= w_next_bank;
                        r_mask  <= r_mask & ~w_bank_1h;
                        if (r_is_store) begin
                            r_hs <= w_bank_1h;
                        end else begin
                            r_hr <= w_bank_1h;
                        end
                        r_state <= c_ST_ISSUE;
                    end else begin
                        r_op_done <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // First WAIT cycle ignores BUSY: the macro may not have raised it yet.
                    if ((r_cnt != '0) && !w_bank_busy) begin
                        r_state <= c_ST_NEXT;
                    end else if (r_cnt == c_WAIT_LAST) begin
                        r_op_err[r_bank] <= 1'b1;
                        r_state          <= c_ST_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_pump_en <= 1'b0;
                    r_rdy     <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_pump_en <= 1'b0;
                    r_rdy     <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (r_rd_bank == c_BANK_W'(i)) begin
                w_rd_word = M_DOUT[i*DATA_W +: DATA_W];
            end
        end
    end

    // Macro presents read data one cycle after CE; capture it the cycle after.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_rd_v    <= 1'b0;
            r_rd_bank <= '0;
            r_dout    <= '0;
            r_dvalid  <= 1'b0;
        end else begin
            r_rd_v    <= w_host_acc & ~WE;
            r_rd_bank <= w_host_bank;
            r_dvalid  <= r_rd_v;
            if (r_rd_v) begin
                r_dout <= w_rd_word;
            end
        end
    end

    assign DOUT    = r_dout;
    assign DVALID  = r_dvalid;
    assign RDY     = r_rdy;
    assign OP_DONE = r_op_done;
    assign OP_ERR  = r_op_err;
    assign M_HS    = r_hs;
    assign M_HR    = r_hr;
    assign PUMP_EN = r_pump_en;

endmodule
`default_nettype wire

// File: tb/tb_nvr_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nvr_seq_ctrl                                              |
// | Description : Scoreboard bench for nvr_seq_ctrl with a behavioural macro.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nvr_seq_ctrl;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int NBANK    = 2;
    localparam int PUMP_CYC = 16;
    localparam int TIMEOUT  = 1023;

    logic                    CLK = 1'b0;
    logic                    RSTN;
    logic                    CE, WE;
    logic [ADDR_W:0]         A;
    logic [DATA_W-1:0]       DIN, DOUT;
    logic                    DVALID, RDY;
    logic                    ST_REQ, RC_REQ;
    logic [NBANK-1:0]        BMASK, OP_ERR;
    logic                    OP_DONE;
    logic [NBANK-1:0]        M_CE, M_HS, M_HR, M_BUSY;
    logic                    M_WE, PUMP_EN;
    logic [ADDR_W-1:0]       M_A;
    logic [DATA_W-1:0]       M_DIN;
    logic [NBANK*DATA_W-1:0] M_DOUT;

    nvr_seq_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBANK(NBANK),
        .PUMP_CYC(PUMP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .CE(CE), .WE(WE), .A(A), .DIN(DIN), .DOUT(DOUT), .DVALID(DVALID), .RDY(RDY),
        .ST_REQ(ST_REQ), .RC_REQ(RC_REQ), .BMASK(BMASK), .OP_DONE(OP_DONE), .OP_ERR(OP_ERR),
        .M_CE(M_CE), .M_WE(M_WE), .M_A(M_A), .M_DIN(M_DIN), .M_DOUT(M_DOUT),
        .M_HS(M_HS), .M_HR(M_HR), .M_BUSY(M_BUSY), .PUMP_EN(PUMP_EN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Behavioural macros: synchronous RAM plus BUSY for 4 cycles after a strobe.
    logic [DATA_W-1:0] mem   [NBANK][2**ADDR_W];
    logic [DATA_W-1:0] mdout [NBANK];
    int                busy_cnt [NBANK];
    logic [NBANK-1:0]  stuck;

    always @(posedge CLK) begin
        for (int i = 0; i < NBANK; i++) begin
            if (M_CE[i]) begin
                if (M_WE) mem[i][M_A] <= M_DIN;
                else      mdout[i]    <= mem[i][M_A];
            end
            if (M_HS[i] || M_HR[i]) busy_cnt[i] <= 4;
            else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always_comb begin
        M_DOUT = '0;
        M_BUSY = '0;
        for (int i = 0; i < NBANK; i++) begin
            M_DOUT[i*DATA_W +: DATA_W] = mdout[i];
            M_BUSY[i] = stuck[i] || (busy_cnt[i] != 0);
        end
    end

    typedef struct { logic [DATA_W-1:0] d; int due; } rd_exp_t;
    typedef struct { bit hs; int bank; int c; } strb_t;

    rd_exp_t          rd_q[$];
    logic [NBANK-1:0] done_q[$];
    strb_t            strb_q[$];
    int               pump_cnt = 0;
    bit               hs_seen  = 1'b0;
    int               done_cyc = 0;

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge CLK) begin
        rd_exp_t          e;
        logic [NBANK-1:0] ee;
        logic [NBANK-1:0] s;
        strb_t            t;
        if (RSTN) begin
            if (DVALID) begin
                if (rd_q.size() == 0) chk("unexpected_dvalid", DVALID, 1'b0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_data", DOUT, e.d);
                    chk("rd_latency", cyc, e.due);
                end
            end
            if (OP_DONE) begin
                done_cyc = cyc;
                if (done_q.size() == 0) chk("unexpected_op_done", OP_DONE, 1'b0);
                else begin
                    ee = done_q.pop_front();
                    chk("op_err", OP_ERR, ee);
                end
            end
            s = M_HS | M_HR;
            if (s != '0) begin
                chk("strobe_onehot", $countones(s), 1);
                t.hs = |M_HS;
                t.c  = cyc;
                t.bank = 0;
                for (int i = 0; i < NBANK; i++) if (s[i]) t.bank = i;
                strb_q.push_back(t);
                hs_seen = 1'b1;
            end
            if (PUMP_EN && !hs_seen) pump_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CE = 1'b0; WE = 1'b0; ST_REQ = 1'b0; RC_REQ = 1'b0; BMASK = '0;
    endtask

    task automatic host_wr(int bank, int addr, logic [DATA_W-1:0] d);
        CE = 1'b1; WE = 1'b1; A = (ADDR_W+1)'(bank * (2**ADDR_W) + addr); DIN = d;
        #1 chk("wr_mce", M_CE, NBANK'(1) << bank);
        tick();
        CE = 1'b0; WE = 1'b0;
    endtask

    task automatic host_rd(int bank, int addr, logic [DATA_W-1:0] d);
        CE = 1'b1; WE = 1'b0; A = (ADDR_W+1)'(bank * (2**ADDR_W) + addr);
        rd_q.push_back('{d: d, due: cyc + 2});
        tick();
        CE = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int n = 0;
        while (!RDY && n < maxc) begin
            tick();
            n++;
        end
        chk("op_finish_in_budget", RDY, 1'b1);
    endtask

    initial begin
        int n;
        idle_inputs();
        stuck = '0; A = '0; DIN = '0; RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rdy", RDY, 1'b1);
        chk("reset_dvalid", DVALID, 1'b0);
        chk("reset_op_done", OP_DONE, 1'b0);
        chk("reset_op_err", OP_ERR, 2'b00);
        chk("reset_pump_en", PUMP_EN, 1'b0);
        chk("reset_hs_hr", {M_HS, M_HR}, 4'b0000);
        chk("reset_dout", DOUT, 32'h0);
        RSTN = 1'b1;
        tick();

        host_wr(1, 5, 32'hDEADBEEF);
        host_wr(0, 5, 32'h12345678);
        host_wr(0, 9, 32'hCAFEF00D);
        host_rd(1, 5, 32'hDEADBEEF);
        host_rd(0, 5, 32'h12345678);
        host_rd(1, 5, 32'hDEADBEEF);
        repeat (3) tick();

        // Op request with an empty mask is ignored
        ST_REQ = 1'b1; BMASK = 2'b00;
        tick();
        idle_inputs();
        chk("empty_mask_rdy", RDY, 1'b1);

        // Store of both banks; recall and host access offered in the same cycle; read in flight
        pump_cnt = 0; hs_seen = 1'b0; strb_q.delete();
        host_rd(0, 9, 32'hCAFEF00D);
        ST_REQ = 1'b1; RC_REQ = 1'b1; BMASK = 2'b11; CE = 1'b1; WE = 1'b0; A = 8'h85;
        #1 chk("op_blocks_host_mce", M_CE, 2'b00);
        done_q.push_back(2'b00);
        tick();
        idle_inputs();
        chk("rdy_low_after_op", RDY, 1'b0);
        wait_idle(200);
        // pump phase plus the bank-select cycle precede the first strobe
        chk("pump_cycles_before_hs", pump_cnt, PUMP_CYC + 1);
        chk("store_strobe_count", strb_q.size(), 2);
        if (strb_q.size() == 2) begin
            chk("store_strobe0", {strb_q[0].hs, 8'(strb_q[0].bank)}, {1'b1, 8'd0});
            chk("store_strobe1", {strb_q[1].hs, 8'(strb_q[1].bank)}, {1'b1, 8'd1});
        end
        chk("pump_off_idle", PUMP_EN, 1'b0);

        // Recall of bank 1 only
        pump_cnt = 0; hs_seen = 1'b0; strb_q.delete();
        RC_REQ = 1'b1; BMASK = 2'b10;
        done_q.push_back(2'b00);
        tick();
        idle_inputs();
        wait_idle(100);
        chk("recall_no_pump", pump_cnt, 0);
        chk("recall_strobe_count", strb_q.size(), 1);
        if (strb_q.size() == 1)
            chk("recall_strobe0", {strb_q[0].hs, 8'(strb_q[0].bank)}, {1'b0, 8'd1});

        // Store with bank 0 stuck busy -> timeout
        stuck = 2'b01; strb_q.delete(); hs_seen = 1'b0;
        ST_REQ = 1'b1; BMASK = 2'b01;
        done_q.push_back(2'b01);
        tick();
        idle_inputs();
        wait_idle(TIMEOUT + 100);
        if (strb_q.size() > 0)
            chk("timeout_latency", done_cyc - strb_q[0].c, TIMEOUT + 2);
        chk("op_err_held", OP_ERR, 2'b01);

        // Reset while waiting on a stuck bank
        strb_q.delete(); hs_seen = 1'b0;
        ST_REQ = 1'b1; BMASK = 2'b01;
        tick();
        idle_inputs();
        n = 0;
        while (strb_q.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("reset_test_reached_wait", strb_q.size(), 1);
        repeat (5) tick();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        chk("midop_rst_rdy", RDY, 1'b1);
        chk("midop_rst_pump", PUMP_EN, 1'b0);
        chk("midop_rst_err", OP_ERR, 2'b00);
        stuck = '0;
        repeat (20) tick();

        chk("rd_queue_drained", rd_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nvr_seq_ctrl.md
NVR_SEQ_CTRL -- requirements
Module: nvr_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, word-address width inside one bank.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter NBANK, default 2, number of NVR macros (power of two, >=2); BANK_W = log2(NBANK).
REQ-004 SHALL have parameter PUMP_CYC, default 16, charge-pump settle cycles before a store (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 1023, maximum cycles waiting for macro BUSY to clear (>=2).
REQ-006 SHALL have ports: CLK in 1 clock; RSTN in 1 reset (one clock; reset is synchronous and active-low).
REQ-007 SHALL have host ports: CE in 1 access request; WE in 1 write when 1; A in BANK_W+ADDR_W address, MSBs = bank; DIN in DATA_W; DOUT out DATA_W read data; DVALID out 1 read-data strobe; RDY out 1 idle/accepting.
REQ-008 SHALL have op ports: ST_REQ in 1 store request; RC_REQ in 1 recall request; BMASK in NBANK banks to process; OP_DONE out 1 completion pulse; OP_ERR out NBANK per-bank timeout flags.
REQ-009 SHALL have macro ports: M_CE out NBANK; M_WE out 1; M_A out ADDR_W; M_DIN out DATA_W; M_DOUT in NBANK*DATA_W (bank i at [i*DATA_W +: DATA_W]); M_HS out NBANK; M_HR out NBANK; M_BUSY in NBANK; PUMP_EN out 1.

Function
REQ-010 SHALL implement FSM states IDLE, PUMP, ISSUE, WAIT, NEXT, DONE; RDY SHALL be 1 exactly when state is IDLE (registered).
REQ-011 In IDLE, ST_REQ=1 with BMASK!=0 SHALL latch BMASK and op type, clear OP_ERR, go to PUMP.
REQ-012 In IDLE, RC_REQ=1 (ST_REQ=0) with BMASK!=0 SHALL latch BMASK, clear OP_ERR, go to NEXT (recall skips the pump).
REQ-013 ST_REQ and RC_REQ together SHALL start a store; recall dropped.
REQ-014 Op requests with BMASK=0 SHALL be ignored (no state change, no OP_DONE).
REQ-015 An accepted op request SHALL take priority over CE in the same cycle; that host access is not accepted.
REQ-016 PUMP: PUMP_EN=1; SHALL stay exactly PUMP_CYC cycles then go to NEXT; PUMP_EN SHALL stay 1 until DONE exits.
REQ-017 NEXT: SHALL select lowest-index set bit of remaining mask, clear it, go to ISSUE; if none remain go to DONE.
REQ-018 ISSUE: SHALL drive M_HS[b] (store) or M_HR[b] (recall) high for exactly one cycle, then WAIT.
REQ-019 WAIT: SHALL ignore M_BUSY[b] in its first cycle, then go to NEXT on first cycle M_BUSY[b]=0.
REQ-020 WAIT: if M_BUSY[b] still 1 after TIMEOUT WAIT cycles, SHALL set OP_ERR[b] and go to NEXT.
REQ-021 DONE: SHALL pulse OP_DONE for one cycle, drop PUMP_EN, return to IDLE; OP_ERR held until next accepted op.
REQ-022 Host access accepted when CE=1 and RDY=1 (no op request): same cycle, combinationally, M_CE[A MSBs]=1, M_WE=WE, M_A=A LSBs, M_DIN=DIN; all M_CE 0 otherwise.
REQ-023 Read (WE=0) accepted in cycle t: SHALL register M_DOUT of that bank at end of t+1, DOUT valid with DVALID=1 in cycle t+2; back-to-back reads SHALL be fully pipelined (one per cycle).
REQ-024 DOUT SHALL hold last read value when DVALID=0; writes SHALL not assert DVALID.
REQ-025 Reads in flight when an op starts SHALL still complete with DVALID.
REQ-026 M_HS/M_HR SHALL never be asserted for more than one bank in the same cycle.

Reset
REQ-027 On RSTN=0 at a CLK edge: state IDLE, RDY=1, DOUT=0, DVALID=0, OP_DONE=0, OP_ERR=0, PUMP_EN=0, M_HS=0, M_HR=0, counters and latched mask 0.
REQ-028 Reset mid-op SHALL abort without OP_DONE; pending read pipeline SHALL be flushed (no DVALID).

Verification
REQ-029 Write bank1 addr 5 = 0xDEADBEEF, read it back (M_DOUT model echoes) -> DVALID exactly 2 cycles after read accept, DOUT=0xDEADBEEF.
REQ-030 ST_REQ, BMASK=2'b11, M_BUSY high 4 cycles after each strobe -> PUMP_EN 16 cycles before M_HS[0], then M_HS[1], OP_DONE once, OP_ERR=0.
REQ-031 RC_REQ, BMASK=2'b10 -> no PUMP cycles, single M_HR[1] pulse, M_HR[0] never, OP_DONE, RDY back to 1.
REQ-032 ST_REQ with M_BUSY[0] stuck 1, BMASK=2'b01 -> after 1023 WAIT cycles OP_ERR=2'b01, OP_DONE asserted.
REQ-033 ST_REQ+RC_REQ+CE same cycle in IDLE -> store runs, no M_CE asserted, RDY=0 next cycle.
REQ-034 RSTN=0 during WAIT -> next cycle RDY=1, PUMP_EN=0, no OP_DONE, OP_ERR=0.
